// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// gemm_pkg: shared GEMM datapath constants and tree-depth helper. Rev 1.0
// ============================================================================
package gemm_pkg;

   localparam int c_ACC_WIDTH = 32;

   function automatic int tree_levels(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
// product_accumulator_if: beat input and result output handshakes. Rev 1.0
// ============================================================================
interface product_accumulator_if import gemm_pkg::*; #(
   parameter int NUM        = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = c_ACC_WIDTH,
   parameter int CNT_WIDTH  = 16
) ();

   logic [NUM-1:0][DATA_WIDTH-1:0] in_data;
   logic                           in_valid;
   logic                           in_last;
   logic                           in_ready;
   logic [ACC_WIDTH-1:0]           out_data;
   logic [CNT_WIDTH-1:0]           out_beats;
   logic                           out_valid;
   logic                           out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_beats, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_beats, out_valid
   );

endinterface
`default_nettype wire

// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// adder_tree_pipe: registered product input stage plus pipelined pairwise
// adder tree with valid/last sideband. Rev 1.0
// ============================================================================
module adder_tree_pipe import gemm_pkg::*; #(
   parameter int NUM        = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = c_ACC_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [NUM-1:0][DATA_WIDTH-1:0] in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic [ACC_WIDTH-1:0]           sum,
   output logic                           sum_valid,
   output logic                           sum_last
);

   localparam int c_LEVELS = tree_levels(NUM);

   // Operands alive at tree level l: ceil(NUM / 2^l).
   function automatic int level_count(input int l);
      return (NUM + (1 << l) - 1) >> l;
   endfunction

   logic [ACC_WIDTH-1:0] w_node [c_LEVELS+1][NUM];
   logic [c_LEVELS:0]    r_valid;
   logic [c_LEVELS:0]    r_last;

   for (genvar i = 0; i < NUM; i++) begin : g_in
      logic [ACC_WIDTH-1:0] r_q;
      always_ff @(posedge clk) begin
         if (rst)
            r_q <= '0;
         else if (en)
            r_q <= ACC_WIDTH'($signed(in_data[i]));
      end
      assign w_node[0][i] = r_q;
   end

   for (genvar l = 0; l < c_LEVELS; l++) begin : g_level
      for (genvar j = 0; j < NUM; j++) begin : g_node
         if (j >= level_count(l + 1)) begin : g_unused
            assign w_node[l+1][j] = '0;
         end else begin : g_used
            logic [ACC_WIDTH-1:0] r_q;
            if (2 * j + 1 < level_count(l)) begin : g_add
               always_ff @(posedge clk) begin
                  if (rst)
                     r_q <= '0;
                  else if (en)
                     r_q <= w_node[l][2*j] + w_node[l][2*j+1];
               end
            end else begin : g_pass
               always_ff @(posedge clk) begin
                  if (rst)
                     r_q <= '0;
                  else if (en)
                     r_q <= w_node[l][2*j];
               end
            end
            assign w_node[l+1][j] = r_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_last  <= '0;
      end else if (en) begin
         r_valid[0] <= in_valid;
         r_last[0]  <= in_last;
         for (int k = 1; k <= c_LEVELS; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_last[k]  <= r_last[k-1];
         end
      end
   end

   assign sum       = w_node[c_LEVELS][0];
   assign sum_valid = r_valid[c_LEVELS];
   assign sum_last  = r_last[c_LEVELS];

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// product_accumulator: reduces NUM products per beat and accumulates beat
// sums into one result per group, with global stall back-pressure. Rev 1.0
// ============================================================================
module product_accumulator import gemm_pkg::*; #(
   parameter int NUM        = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = c_ACC_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   product_accumulator_if.slave  bus
);

   logic                 w_stall;
   logic                 w_en;
   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_sum_valid;
   logic                 w_sum_last;
   logic [ACC_WIDTH-1:0] w_acc_next;
   logic [CNT_WIDTH-1:0] w_cnt_next;

   logic [ACC_WIDTH-1:0] r_acc;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_first;
   logic [ACC_WIDTH-1:0] r_out_data;
   logic [CNT_WIDTH-1:0] r_out_beats;
   logic                 r_out_valid;

   // A held result the consumer refuses freezes the whole pipeline.
   assign w_stall      = r_out_valid && !bus.out_ready;
   assign w_en         = !w_stall;
   assign bus.in_ready = w_en;

   adder_tree_pipe #(
      .NUM        (NUM),
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_tree (
      .clk       (clk),
      .rst       (rst),
      .en        (w_en),
      .in_data   (bus.in_data),
      .in_valid  (bus.in_valid),
      .in_last   (bus.in_last),
      .sum       (w_sum),
      .sum_valid (w_sum_valid),
      .sum_last  (w_sum_last)
   );

   assign w_acc_next = r_first ? w_sum : r_acc + w_sum;
   assign w_cnt_next = r_first ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_first     <= 1'b1;
         r_out_data  <= '0;
         r_out_beats <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_out_valid && bus.out_ready)
            r_out_valid <= 1'b0;
         // A new result may overwrite the register the same cycle it is taken.
         if (w_en && w_sum_valid) begin
            if (w_sum_last) begin
               r_out_data  <= w_acc_next;
               r_out_beats <= w_cnt_next;
               r_out_valid <= 1'b1;
               r_first     <= 1'b1;
            end else begin
               r_acc   <= w_acc_next;
               r_cnt   <= w_cnt_next;
               r_first <= 1'b0;
            end
         end
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_beats = r_out_beats;
   assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
